instr_mem_loader: RTL and testbench

//  Write-side companion to the instruction memory.

---
 rtl/instr_mem_loader_if.sv | 22 ++
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream in / memory word-write out bundle for the instruction memory loader.
// master drives the byte stream and observes writes; slave is the loader itself.
interface instr_mem_loader_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [31:0]              wr_data;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as little-endian words, holding the CPU meanwhile.
// One word per 5 cycles at best (4 byte cycles + 1 write cycle); rx_ready drops in WRITE/DONE/ERR/IDLE.
module instr_mem_loader #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_mem_loader_if.slave   bus,
    output logic                busy,
    output logic                cpu_hold,
    output logic                done,
    output logic                err
);
    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR
    } state_t;

    localparam logic [63:0] MEM_BYTES = 64'd1 << MEM_ADDR_BITS;

    state_t                   state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [15:0]              word_idx_q, word_idx_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [31:0]              word_q, word_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]              wr_data_q, wr_data_d;
    logic                     err_q, err_d;

    logic        rx_ready;
    logic        fire;
    logic [15:0] n_new;
    logic [63:0] end_addr;

    // Wide compare so an oversized image can never wrap back into range.
    assign n_new    = {bus.rx_data, len_q[7:0]};
    assign end_addr = 64'(BASE_ADDR) + {46'd0, n_new, 2'b00};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;

        rx_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
        fire     = bus.rx_valid && rx_ready;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LEN0;
                    err_d   = 1'b0;
                end
            end
            LEN0: begin
                if (fire) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (fire) begin
                    len_d[15:8] = bus.rx_data;
                    if (n_new == 16'd0) begin
                        state_d = DONE;
                    end else if (end_addr > MEM_BYTES) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = DATA;
                        word_idx_d = 16'd0;
                        byte_cnt_d = 2'd0;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d   = WRITE;
                        wr_addr_d = BASE_ADDR + ADDRESS_WIDTH'({word_idx_q, 2'b00});
                        wr_data_d = word_d;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                if (({1'b0, word_idx_q} + 17'd1) == {1'b0, len_q}) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    assign bus.rx_ready = rx_ready;
    assign bus.wr_en    = (state_q == WRITE);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state_q != IDLE);
    assign cpu_hold     = busy;
    assign done         = (state_q == DONE);
    assign err          = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: table of small loads plus hand-written reset, empty, full-memory and abort sequences.
// Expected writes go into a scoreboard queue and are checked by a negedge monitor.
module tb_instr_mem_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic start = 1'b0;
    logic busy, cpu_hold, done, err;

    instr_mem_loader_if #(.ADDRESS_WIDTH(32)) ifc();

    instr_mem_loader #(
        .ADDRESS_WIDTH(32),
        .MEM_ADDR_BITS(12),
        .BASE_ADDR    (32'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (ifc),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int          nb;
        logic [7:0]  b [10];
        bit          gaps;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
        logic [31:0] exp_w [2];
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  sb [$];
    wr_t  exp_wr;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    bit   err_seen = 1'b0;
    bit   prev_wr = 1'b0;
    bit   gaps = 1'b0;
    logic [31:0] last_addr = '0;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ifc.wr_en) begin
                chk("rx_ready_in_write", 32'(ifc.rx_ready), 32'd0);
                chk("wr_en_single_cycle", 32'(prev_wr), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                             ifc.wr_addr, ifc.wr_data);
                end else begin
                    exp_wr = sb.pop_front();
                    chk("wr_addr", ifc.wr_addr, exp_wr.addr);
                    chk("wr_data", ifc.wr_data, exp_wr.data);
                end
                wr_cnt++;
                last_addr = ifc.wr_addr;
            end
            if (done) done_cnt++;
            if (err)  err_seen = 1'b1;
            chk("cpu_hold_eq_busy", 32'(cpu_hold), 32'(busy));
            prev_wr = ifc.wr_en;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                ifc.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        ifc.rx_data  = b;
        ifc.rx_valid = 1'b1;
        while (!ifc.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: byte 0x%02h not accepted in 50 cycles", b);
        end
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_cnt   = 0;
        done_cnt = 0;
        err_seen = 1'b0;
        chk({name, "_err_cleared"}, 32'(err), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic finish_load(input string name, input bit exp_done, input bit exp_err, input int exp_writes);
        int t = 0;
        while (done_cnt == 0 && !err_seen && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
        chk({name, "_err"}, 32'(err), 32'(exp_err));
        chk({name, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
        chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        if (exp_err) chk({name, "_rx_ready_after_err"}, 32'(ifc.rx_ready), 32'd0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        gaps = v.gaps;
        do_start(v.name);
        for (int i = 0; i < v.exp_writes; i++) sb.push_back('{32'(4 * i), v.exp_w[i]});
        for (int k = 0; k < v.nb; k++) send_byte(v.b[k]);
        finish_load(v.name, v.exp_done, v.exp_err, v.exp_writes);
        if (v.exp_writes > 0) begin
            chk({v.name, "_wr_addr_hold"}, ifc.wr_addr, 32'(4 * (v.exp_writes - 1)));
            chk({v.name, "_wr_data_hold"}, ifc.wr_data, v.exp_w[v.exp_writes - 1]);
        end
        gaps = 1'b0;
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{"two_words", 10,
                    '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00},
                    1'b0, 1'b1, 1'b0, 2, '{32'h0000_0013, 32'h0010_00B3}};
        vecs[1] = '{"one_word", 6,
                    '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00},
                    1'b0, 1'b1, 1'b0, 1, '{32'hDEAD_BEEF, 32'h0}};
        vecs[2] = '{"too_long", 2,
                    '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1'b0, 1'b0, 1'b1, 0, '{32'h0, 32'h0}};
        vecs[3] = '{"two_words_gaps", 10,
                    '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h10, 8'h00},
                    1'b1, 1'b1, 1'b0, 2, '{32'h0000_0013, 32'h0010_00B3}};

        // Reset state, with a byte offered the whole time.
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'hA5;
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", 32'(ifc.rx_ready), 32'd0);
        chk("rst_wr_en",    32'(ifc.wr_en),    32'd0);
        chk("rst_wr_addr",  ifc.wr_addr,       32'd0);
        chk("rst_wr_data",  ifc.wr_data,       32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold),     32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_err",      32'(err),          32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_rx_ready_with_valid", 32'(ifc.rx_ready), 32'd0);
        end
        ifc.rx_valid = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Zero-length image: done on the cycle right after the second length byte.
        do_start("zero_len");
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zero_len_done_now", 32'(done), 32'd1);
        @(negedge clk);
        chk("zero_len_done_gone", 32'(done), 32'd0);
        chk("zero_len_busy_gone", 32'(busy), 32'd0);
        chk("zero_len_writes", 32'(wr_cnt), 32'd0);

        // Oversized image flags err, then a full 4 KiB image loads cleanly.
        run_vec(vecs[2]);
        do_start("full_mem");
        send_byte(8'h00);
        send_byte(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = {8'(i) ^ 8'h5A, 8'(i >> 8), ~8'(i), 8'(i)};
            sb.push_back('{32'(4 * i), w});
            send_byte(w[7:0]);
            send_byte(w[15:8]);
            send_byte(w[23:16]);
            send_byte(w[31:24]);
        end
        finish_load("full_mem", 1'b1, 1'b0, 1024);
        chk("full_mem_last_addr", last_addr, 32'h0000_0FFC);

        // Reset after six payload bytes: first word kept, partial second word dropped.
        do_start("abort");
        sb.push_back('{32'h0, 32'h0000_0013});
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hB3);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_cpu_hold", 32'(cpu_hold), 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_writes",  32'(wr_cnt),    32'd1);
        chk("abort_sb_left", 32'(sb.size()), 32'd0);
        chk("abort_idle",    32'(busy),      32'd0);
        sb.delete();
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
